nios_core_debug_cmd_decoder: RTL and testbench

NIOS_CORE_DEBUG_CMD_DECODER -- requirements
Module: nios_core_debug_cmd_decoder

---
 rtl/nios_core_debug_cmd_decoder_if.sv | 43 ++++
 rtl/nios_core_debug_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_nios_core_debug_cmd_decoder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_core_debug_cmd_decoder_if.sv
// JTAG-side command inputs and core-side action outputs of the debug command decoder.
interface nios_core_debug_cmd_decoder_if #(
  parameter int unsigned SR_W  = 38,
  parameter int unsigned IR_W  = 2,
  parameter int unsigned CNT_W = 8
);
  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic             vs_uir;
  logic             vs_udr;
  logic             dbg_ready;
  logic             clr_overrun;
  logic [SR_W-1:0]  jdo;
  logic             take_action_ocimem_a;
  logic             take_action_ocimem_b;
  logic             take_no_action_ocimem_a;
  logic             take_action_break_a;
  logic             take_action_break_b;
  logic             take_action_break_c;
  logic             take_no_action_break_a;
  logic             take_no_action_break_b;
  logic             take_no_action_break_c;
  logic             take_action_tracectrl;
  logic             cmd_err;
  logic             cmd_overrun;
  logic [CNT_W-1:0] cmd_count;

  modport slave (
    input  ir_in, sr, vs_uir, vs_udr, dbg_ready, clr_overrun,
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
           take_action_tracectrl, cmd_err, cmd_overrun, cmd_count
  );

  modport master (
    output ir_in, sr, vs_uir, vs_udr, dbg_ready, clr_overrun,
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
           take_action_tracectrl, cmd_err, cmd_overrun, cmd_count
  );
endinterface

// File: rtl/nios_core_debug_cmd_decoder.sv
// Synchronises JTAG update strobes, queues {IR, sr} commands and issues decoded action pulses.
// Optional trace-control command decode enabled by defining NIOS_DEBUG_SLAVE_TRACECTRL_EN.
module nios_core_debug_cmd_decoder #(
  parameter int unsigned SR_W      = 38,
  parameter int unsigned IR_W      = 2,
  parameter int unsigned CMD_DEPTH = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  nios_core_debug_cmd_decoder_if.slave bus
);

  localparam int unsigned ENT_W  = IR_W + SR_W;
  localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(CMD_DEPTH + 1);

  // [0]/[1] synchroniser, [2] edge-detect
  logic [2:0] uir_s, udr_s;
  logic [1:0] settle_q;
  logic       uir_arm_q, udr_arm_q;
  logic       uir_rise_c, udr_rise_c;

  // A level held high through reset must fall before an edge is recognised.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_s     <= '0;
      udr_s     <= '0;
      settle_q  <= '0;
      uir_arm_q <= 1'b0;
      udr_arm_q <= 1'b0;
    end else begin
      uir_s    <= {uir_s[1:0], bus.vs_uir};
      udr_s    <= {udr_s[1:0], bus.vs_udr};
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && !uir_s[1]) uir_arm_q <= 1'b1;
      if (settle_q[1] && !udr_s[1]) udr_arm_q <= 1'b1;
    end
  end

  assign uir_rise_c = uir_s[1] & ~uir_s[2] & uir_arm_q;
  assign udr_rise_c = udr_s[1] & ~udr_s[2] & udr_arm_q;

  logic [IR_W-1:0] ir_q;

  always_ff @(posedge clk) begin
    if (reset)           ir_q <= '0;
    else if (uir_rise_c) ir_q <= bus.ir_in;
  end

  // Command FIFO
  logic [ENT_W-1:0]  mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              full_c, empty_c, rd_c, wr_c, drop_c;

  assign full_c  = (fill_q == FILL_W'(CMD_DEPTH));
  assign empty_c = (fill_q == '0);
  assign rd_c    = !empty_c && bus.dbg_ready;
  assign wr_c    = udr_rise_c && (!full_c || rd_c);
  assign drop_c  = udr_rise_c && !wr_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= {ir_q, bus.sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_c, rd_c})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Decode of the FIFO head
  logic [ENT_W-1:0] head_c;
  logic [IR_W-1:0]  hir_c;
  logic [SR_W-1:0]  hsr_c;
  logic             f1_c, f2_c, f3_c;
  logic [8:0]       pulse_c;
  logic             err_c;
`ifdef NIOS_DEBUG_SLAVE_TRACECTRL_EN
  logic             trace_c;
`endif

  assign head_c = mem_q[rd_ptr_q];
  assign hir_c  = head_c[ENT_W-1:SR_W];
  assign hsr_c  = head_c[SR_W-1:0];
  assign f1_c   = hsr_c[SR_W-3];
  assign f2_c   = hsr_c[SR_W-4];
  assign f3_c   = hsr_c[SR_W-5];

  // pulse_c: [8] ocimem_a [7] ocimem_b [6] no_ocimem_a [5:3] break a..c [2:0] no_break a..c
  always_comb begin
    pulse_c = '0;
    err_c   = 1'b0;
`ifdef NIOS_DEBUG_SLAVE_TRACECTRL_EN
    trace_c = 1'b0;
`endif
    case (hir_c)
      IR_W'(0): begin
        if (f1_c)       pulse_c[f2_c ? 7 : 8] = 1'b1;
        else if (!f2_c) pulse_c[6] = 1'b1;
        else            err_c = 1'b1;
      end
      IR_W'(1): begin
`ifdef NIOS_DEBUG_SLAVE_TRACECTRL_EN
        trace_c = f1_c;
`else
        err_c = 1'b1;
`endif
      end
      IR_W'(2): begin
        case ({f2_c, f3_c})
          2'b00:   pulse_c[f1_c ? 5 : 2] = 1'b1;
          2'b01:   pulse_c[f1_c ? 4 : 1] = 1'b1;
          2'b10:   pulse_c[f1_c ? 3 : 0] = 1'b1;
          default: err_c = 1'b1;
        endcase
      end
      IR_W'(3): ;
      default: err_c = 1'b1;
    endcase
  end

  // Registered issue outputs, overrun flag and accepted-command counter
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.jdo         <= '0;
      {bus.take_action_ocimem_a, bus.take_action_ocimem_b, bus.take_no_action_ocimem_a,
       bus.take_action_break_a, bus.take_action_break_b, bus.take_action_break_c,
       bus.take_no_action_break_a, bus.take_no_action_break_b,
       bus.take_no_action_break_c} <= '0;
      bus.cmd_err     <= 1'b0;
      bus.cmd_overrun <= 1'b0;
      bus.cmd_count   <= '0;
    end else begin
      if (rd_c) bus.jdo <= hsr_c;
      {bus.take_action_ocimem_a, bus.take_action_ocimem_b, bus.take_no_action_ocimem_a,
       bus.take_action_break_a, bus.take_action_break_b, bus.take_action_break_c,
       bus.take_no_action_break_a, bus.take_no_action_break_b,
       bus.take_no_action_break_c} <= rd_c ? pulse_c : '0;
      bus.cmd_err <= rd_c & err_c;
      if (drop_c)               bus.cmd_overrun <= 1'b1;
      else if (bus.clr_overrun) bus.cmd_overrun <= 1'b0;
      if (wr_c) bus.cmd_count <= bus.cmd_count + CNT_W'(1);
    end
  end

`ifdef NIOS_DEBUG_SLAVE_TRACECTRL_EN
  always_ff @(posedge clk) begin
    if (reset) bus.take_action_tracectrl <= 1'b0;
    else       bus.take_action_tracectrl <= rd_c & trace_c;
  end
`else
  assign bus.take_action_tracectrl = 1'b0;
`endif

endmodule

// File: tb/tb_nios_core_debug_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected issues, a negedge monitor pops and compares them.
module tb_nios_core_debug_cmd_decoder;

  localparam int unsigned SR_W  = 38;
  localparam int unsigned IR_W  = 2;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_core_debug_cmd_decoder_if #(.SR_W(SR_W), .IR_W(IR_W), .CNT_W(CNT_W)) bus ();

  nios_core_debug_cmd_decoder #(
    .SR_W(SR_W), .IR_W(IR_W), .CMD_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [10:0]     vec;
    logic [SR_W-1:0] jdo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_count = 0;

  // {err, oc_a, oc_b, no_oc_a, br_a, br_b, br_c, nbr_a, nbr_b, nbr_c, trace}
  logic [10:0] out_vec;
  assign out_vec = {bus.cmd_err, bus.take_action_ocimem_a, bus.take_action_ocimem_b,
                    bus.take_no_action_ocimem_a, bus.take_action_break_a,
                    bus.take_action_break_b, bus.take_action_break_c,
                    bus.take_no_action_break_a, bus.take_no_action_break_b,
                    bus.take_no_action_break_c, bus.take_action_tracectrl};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any pulse or jdo change is an issue and must match the scoreboard head.
  logic [SR_W-1:0] prev_jdo = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_jdo = '0;
    end else begin
      if (out_vec != 11'h0 || bus.jdo != prev_jdo) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got vec %0h jdo %0h expected no issue", out_vec, bus.jdo);
        end else begin
          mon_e = sb_q.pop_front();
          chk("issue_vec", 64'(out_vec), 64'(mon_e.vec));
          chk("issue_jdo", 64'(bus.jdo), 64'(mon_e.jdo));
        end
      end
      prev_jdo = bus.jdo;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_ir(input logic [IR_W-1:0] ir);
    bus.ir_in  = ir;
    bus.vs_uir = 1'b1;
    tick(3);
    bus.vs_uir = 1'b0;
    tick(3);
  endtask

  task automatic do_udr(input logic [SR_W-1:0] s, input bit accept, input logic [10:0] vec);
    bus.sr     = s;
    bus.vs_udr = 1'b1;
    if (accept) begin
      sb_q.push_back('{vec: vec, jdo: s});
      exp_count++;
    end
    tick(3);
    bus.vs_udr = 1'b0;
    tick(3);
  endtask

  function automatic logic [SR_W-1:0] mk_sr(input logic [2:0] f, input logic [31:0] p);
    return {2'b10, f, 1'b0, p};
  endfunction

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [2:0]      f;    // {F1, F2, F3}
    logic [10:0]     vec;
  } vec_t;

  localparam logic [10:0] ERR = 11'h400;
`ifdef NIOS_DEBUG_SLAVE_TRACECTRL_EN
  localparam logic [10:0] IR1_F1  = 11'h001;
  localparam logic [10:0] IR1_NF1 = 11'h000;
`else
  localparam logic [10:0] IR1_F1  = ERR;
  localparam logic [10:0] IR1_NF1 = ERR;
`endif

  vec_t vtab [14];
  logic [SR_W-1:0] s_a, s_b, s_lat;

  initial begin
    vtab[0]  = '{ir: 2'd0, f: 3'b100, vec: 11'h200};
    vtab[1]  = '{ir: 2'd0, f: 3'b110, vec: 11'h100};
    vtab[2]  = '{ir: 2'd0, f: 3'b001, vec: 11'h080};
    vtab[3]  = '{ir: 2'd0, f: 3'b010, vec: ERR};
    vtab[4]  = '{ir: 2'd2, f: 3'b100, vec: 11'h040};
    vtab[5]  = '{ir: 2'd2, f: 3'b101, vec: 11'h020};
    vtab[6]  = '{ir: 2'd2, f: 3'b110, vec: 11'h010};
    vtab[7]  = '{ir: 2'd2, f: 3'b000, vec: 11'h008};
    vtab[8]  = '{ir: 2'd2, f: 3'b001, vec: 11'h004};
    vtab[9]  = '{ir: 2'd2, f: 3'b010, vec: 11'h002};
    vtab[10] = '{ir: 2'd2, f: 3'b111, vec: ERR};
    vtab[11] = '{ir: 2'd3, f: 3'b110, vec: 11'h000};
    vtab[12] = '{ir: 2'd1, f: 3'b100, vec: IR1_F1};
    vtab[13] = '{ir: 2'd1, f: 3'b011, vec: IR1_NF1};

    reset           = 1'b1;
    bus.ir_in       = '0;
    bus.sr          = '0;
    bus.vs_uir      = 1'b0;
    bus.vs_udr      = 1'b0;
    bus.dbg_ready   = 1'b0;
    bus.clr_overrun = 1'b0;
    tick(3);
    chk("rst_pulses", 64'(out_vec), 64'h0);
    chk("rst_jdo", 64'(bus.jdo), 64'h0);
    chk("rst_count", 64'(bus.cmd_count), 64'h0);
    chk("rst_overrun", 64'(bus.cmd_overrun), 64'h0);
    reset = 1'b0;
    exp_count = 0;
    tick(3);
    bus.dbg_ready = 1'b1;

    // Latency: udr first sampled at E1, pulse visible only after E4
    set_ir(2'd0);
    s_lat = mk_sr(3'b100, 32'h1234_5678);
    bus.sr = s_lat;
    bus.vs_udr = 1'b1;
    sb_q.push_back('{vec: 11'h200, jdo: s_lat});
    exp_count++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat_e3_no_pulse", 64'(bus.take_action_ocimem_a), 64'h0);
    @(posedge clk); #1;
    chk("lat_e4_pulse", 64'(bus.take_action_ocimem_a), 64'h1);
    chk("lat_e4_jdo", 64'(bus.jdo), 64'(s_lat));
    bus.vs_udr = 1'b0;
    @(posedge clk); #1;
    chk("lat_e5_single", 64'(bus.take_action_ocimem_a), 64'h0);
    tick(3);

    // Decode table
    for (int i = 0; i < 14; i++) begin
      set_ir(vtab[i].ir);
      do_udr(mk_sr(vtab[i].f, 32'hA5A5_0000 + 32'(i)), 1'b1, vtab[i].vec);
    end
    tick(4);
    chk("count_after_table", 64'(bus.cmd_count), 64'(CNT_W'(exp_count)));
    chk("no_overrun_yet", 64'(bus.cmd_overrun), 64'h0);

    // Overrun: two fit, third dropped, then drain in order on consecutive cycles
    bus.dbg_ready = 1'b0;
    set_ir(2'd0);
    s_a = mk_sr(3'b100, 32'h0000_0001);
    s_b = mk_sr(3'b110, 32'h0000_0002);
    do_udr(s_a, 1'b1, 11'h200);
    do_udr(s_b, 1'b1, 11'h100);
    do_udr(mk_sr(3'b100, 32'h0000_0003), 1'b0, 11'h000);
    chk("ovr_count", 64'(bus.cmd_count), 64'(CNT_W'(exp_count)));
    chk("ovr_flag", 64'(bus.cmd_overrun), 64'h1);
    bus.dbg_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain0_jdo", 64'(bus.jdo), 64'(s_a));
    chk("drain0_pulse", 64'(bus.take_action_ocimem_a), 64'h1);
    @(posedge clk); #1;
    chk("drain1_jdo", 64'(bus.jdo), 64'(s_b));
    chk("drain1_pulse", 64'(bus.take_action_ocimem_b), 64'h1);
    @(posedge clk); #1;
    chk("drain_done", 64'(out_vec), 64'h0);
    tick(2);

    // clr_overrun alone clears; with a simultaneous drop the flag stays set
    bus.clr_overrun = 1'b1;
    tick(1);
    bus.clr_overrun = 1'b0;
    chk("clr_overrun", 64'(bus.cmd_overrun), 64'h0);
    bus.dbg_ready = 1'b0;
    do_udr(mk_sr(3'b000, 32'h0000_0004), 1'b1, 11'h080);
    do_udr(mk_sr(3'b100, 32'h0000_0005), 1'b1, 11'h200);
    bus.sr = mk_sr(3'b100, 32'h0000_0006);
    bus.vs_udr = 1'b1;
    tick(2);
    bus.clr_overrun = 1'b1;
    tick(1);
    bus.clr_overrun = 1'b0;
    chk("drop_beats_clr", 64'(bus.cmd_overrun), 64'h1);
    bus.vs_udr = 1'b0;
    tick(3);
    bus.dbg_ready = 1'b1;
    tick(4);

    // Reset with two queued commands and udr held high
    bus.dbg_ready = 1'b0;
    do_udr(mk_sr(3'b100, 32'h0000_0007), 1'b1, 11'h200);
    do_udr(mk_sr(3'b110, 32'h0000_0008), 1'b1, 11'h100);
    bus.sr = mk_sr(3'b100, 32'h0000_0009);
    bus.vs_udr = 1'b1;
    tick(3);
    reset = 1'b1;
    sb_q.delete();
    tick(2);
    chk("midrst_count", 64'(bus.cmd_count), 64'h0);
    chk("midrst_overrun", 64'(bus.cmd_overrun), 64'h0);
    reset = 1'b0;
    exp_count = 0;
    bus.dbg_ready = 1'b1;
    tick(8);
    chk("held_udr_no_edge", 64'(bus.cmd_count), 64'h0);
    bus.vs_udr = 1'b0;
    tick(3);
    do_udr(mk_sr(3'b100, 32'h0000_000A), 1'b1, 11'h200);
    tick(2);
    chk("post_rst_count", 64'(bus.cmd_count), 64'h1);

    // Counter wrap over 256 accepted TRACEMEM reads
    reset = 1'b1;
    sb_q.delete();
    tick(2);
    reset = 1'b0;
    exp_count = 0;
    tick(3);
    set_ir(2'd3);
    for (int i = 0; i < 256; i++) begin
      do_udr(mk_sr(3'b000, 32'h100 + 32'(i)), 1'b1, 11'h000);
      if (i == 254) chk("count_255", 64'(bus.cmd_count), 64'hFF);
    end
    chk("count_wrap", 64'(bus.cmd_count), 64'h0);

    tick(5);
    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
